t01_score_bcd_display: RTL and testbench

Next-generation score overlay for the team 01 VGA pipeline. It renders the label "SCORE" and an N-digit decimal value, scaled up by an integer factor.
- Binary-to-BCD conversion is a sequential double-dabble FSM, not combinational divide/modulo.
- Pixel colour comes through a 2-stage registered pipeline.
- Adds leading-zero blanking, overflow saturation and a frame-counted flash on score change.
- Sits beside the other shape generators; its shape_color feeds the pixel colour mux.

---
 rtl/t01_display_pkg.sv | 31 +++
 rtl/t01_font_rom.sv | 38 +++
 rtl/t01_score_bcd_display.sv | 206 ++++++++++++++++++++
 tb/tb_t01_score_bcd_display.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/t01_display_pkg.sv
// Shared types and constants for the score overlay: colours, glyph cell size,
// glyph indices, converter states and pixel-region tags.
package t01_display_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 12;

  typedef enum logic [3:0] {
    G_0 = 4'd0, G_1 = 4'd1, G_2 = 4'd2, G_3 = 4'd3, G_4 = 4'd4,
    G_5 = 4'd5, G_6 = 4'd6, G_7 = 4'd7, G_8 = 4'd8, G_9 = 4'd9,
    G_S = 4'd10, G_C = 4'd11, G_O = 4'd12, G_R = 4'd13, G_E = 4'd14,
    G_BLANK = 4'd15
  } glyph_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} conv_state_e;

  typedef enum logic [1:0] {HIT_NONE, HIT_LABEL, HIT_VALUE} hit_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/t01_font_rom.sv
// 8x12 glyph ROM: digits 0-9, S C O R E, blank; MSB is the leftmost column.
// Combinational, zero latency; no flow control.
module t01_font_rom
  import t01_display_pkg::*;
(
  input  logic [3:0] glyph,
  input  logic [3:0] row,
  output logic [7:0] bits
);

  logic [95:0] g;

  // Each glyph is 12 rows of 8 bits, row 0 in the top byte.
  always_comb begin
    g = '0;
    case (glyph)
      G_0:     g = 96'h3C66_6666_6E76_6666_6666_3C00;
      G_1:     g = 96'h1838_7818_1818_1818_1818_7E00;
      G_2:     g = 96'h3C66_6606_0C18_3060_6066_7E00;
      G_3:     g = 96'h3C66_0606_1C06_0606_0666_3C00;
      G_4:     g = 96'h6666_6666_667E_0606_0606_0600;
      G_5:     g = 96'h7E60_6060_7C06_0606_0666_3C00;
      G_6:     g = 96'h3C66_6060_7C66_6666_6666_3C00;
      G_7:     g = 96'h7E06_060C_0C18_1830_3030_3000;
      G_8:     g = 96'h3C66_6666_3C66_6666_6666_3C00;
      G_9:     g = 96'h3C66_6666_663E_0606_0666_3C00;
      G_S:     g = 96'h3C66_6060_3C06_0606_0666_3C00;
      G_C:     g = 96'h3C66_6060_6060_6060_6066_3C00;
      G_O:     g = 96'h3C66_6666_6666_6666_6666_3C00;
      G_R:     g = 96'h7C66_6666_7C78_6C66_6666_6600;
      G_E:     g = 96'h7E60_6060_7C60_6060_6060_7E00;
      default: g = '0;
    endcase
    bits = 8'h00;
    if (row < 4'(CHAR_H)) bits = g[8*(11 - int'(row)) +: 8];
  end

endmodule

// File: rtl/t01_score_bcd_display.sv
// Score overlay: "SCORE" label plus N-digit decimal value via sequential double-dabble.
// Pixel colour 2 cycles after x/y; digits update SCORE_W+2 cycles after a score change.
// No backpressure: score changes during a conversion are picked up once it completes.
module t01_score_bcd_display
  import t01_display_pkg::*;
#(
  parameter int SCORE_W      = 14,
  parameter int DIGITS       = 4,
  parameter int SCALE        = 2,
  parameter int ORIGIN_X     = 245,
  parameter int ORIGIN_Y     = 400,
  parameter int VALUE_GAP    = 90,
  parameter int BLANK_LZ     = 1,
  parameter int FLASH_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               frame_tick,
  output logic               busy,
  output logic [2:0]         shape_color
);

  localparam int BCD_W    = 4 * DIGITS;
  localparam int CNT_W    = $clog2(SCORE_W + 1);
  localparam int FL_W     = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam int SCALE_SH = $clog2(SCALE);
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

  localparam logic [10:0] Y0  = 11'(ORIGIN_Y);
  localparam logic [10:0] Y1  = 11'(ORIGIN_Y + CHAR_H * SCALE);
  localparam logic [10:0] LX0 = 11'(ORIGIN_X);
  localparam logic [10:0] LX1 = 11'(ORIGIN_X + 5 * CHAR_W * SCALE);
  localparam logic [10:0] VX0 = 11'(ORIGIN_X + VALUE_GAP);
  localparam logic [10:0] VX1 = 11'(ORIGIN_X + VALUE_GAP + CHAR_W * SCALE * DIGITS);

  conv_state_e        state_q, state_d;
  logic [SCORE_W-1:0] work_q, work_d, cap_q, cap_d, shadow_q, shadow_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FL_W-1:0]    flash_q, flash_d;
  logic               busy_q, busy_d;

  hit_e               s1_hit_q, s1_hit_d;
  logic [3:0]         s1_glyph_q, s1_glyph_d;
  logic [3:0]         s1_row_q, s1_row_d;
  logic [2:0]         s1_col_q, s1_col_d;
  logic [2:0]         shape_color_q, shape_color_d;

  logic [BCD_W-1:0]   bcd_adj, bcd_shift;
  logic [DIGITS-1:0]  lz;
  logic               zero_run;
  logic [10:0]        x11, y11, lcell, vcell;
  logic               in_y;
  logic [7:0]         font_bits;
  logic               pix_on;

  // Converter: one double-dabble step per SHIFT cycle; the result is committed
  // on the final step so the new digits are visible while the FSM sits in DONE.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], work_q[SCORE_W-1]};

    state_d  = state_q;
    work_d   = work_q;
    cap_d    = cap_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    flash_d  = flash_q;

    if (frame_tick && (flash_q != '0)) flash_d = flash_q - FL_W'(1);

    case (state_q)
      S_IDLE: begin
        if (score != shadow_q) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        // Shadow keeps the raw score so a saturated value does not re-trigger.
        cap_d   = score;
        work_d  = (32'(score) >= LIMIT) ? SCORE_W'(LIMIT - 32'd1) : score;
        bcd_d   = '0;
        cnt_d   = CNT_W'(SCORE_W);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d  = bcd_shift;
        work_d = {work_q[SCORE_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          digits_d = bcd_shift;
          shadow_d = cap_q;
          busy_d   = 1'b0;
          if (bcd_shift != digits_q) flash_d = FL_W'(FLASH_FRAMES);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Leading-zero flags; the least significant digit is never blanked.
  always_comb begin
    lz       = '0;
    zero_run = (BLANK_LZ != 0);
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (digits_q[4*(DIGITS-1-i) +: 4] != 4'd0) zero_run = 1'b0;
      lz[i] = zero_run;
    end
  end

  // Stage 1: region hit, glyph, row and column from the current pixel.
  always_comb begin
    x11   = {1'b0, x};
    y11   = {1'b0, y};
    in_y  = (y11 >= Y0) && (y11 < Y1);
    lcell = (x11 - LX0) >> SCALE_SH;
    vcell = (x11 - VX0) >> SCALE_SH;

    s1_hit_d   = HIT_NONE;
    s1_glyph_d = 4'(G_BLANK);
    s1_row_d   = 4'((y11 - Y0) >> SCALE_SH);
    s1_col_d   = 3'd0;

    if (in_y && (x11 >= LX0) && (x11 < LX1)) begin
      s1_hit_d   = HIT_LABEL;
      s1_glyph_d = 4'(G_S) + 4'(lcell[10:3]);
      s1_col_d   = lcell[2:0];
    end else if (in_y && (x11 >= VX0) && (x11 < VX1)) begin
      s1_hit_d = HIT_VALUE;
      s1_col_d = vcell[2:0];
      for (int i = 0; i < DIGITS; i++) begin
        if (vcell[10:3] == 8'(i))
          s1_glyph_d = lz[i] ? 4'(G_BLANK) : digits_q[4*(DIGITS-1-i) +: 4];
      end
    end
  end

  t01_font_rom u_font (
    .glyph (s1_glyph_q),
    .row   (s1_row_q),
    .bits  (font_bits)
  );

  // Stage 2: font lookup and colour select.
  always_comb begin
    pix_on        = font_bits[3'd7 - s1_col_q];
    shape_color_d = BLACK;
    if (pix_on) begin
      case (s1_hit_q)
        HIT_LABEL: shape_color_d = YELLOW;
        HIT_VALUE: shape_color_d = ((flash_q != '0) && flash_q[0]) ? GREEN : WHITE;
        default:   shape_color_d = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      work_q        <= '0;
      cap_q         <= '0;
      shadow_q      <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      digits_q      <= '0;
      flash_q       <= '0;
      busy_q        <= 1'b0;
      s1_hit_q      <= HIT_NONE;
      s1_glyph_q    <= '0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      shape_color_q <= BLACK;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cap_q         <= cap_d;
      shadow_q      <= shadow_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      flash_q       <= flash_d;
      busy_q        <= busy_d;
      s1_hit_q      <= s1_hit_d;
      s1_glyph_q    <= s1_glyph_d;
      s1_row_q      <= s1_row_d;
      s1_col_q      <= s1_col_d;
      shape_color_q <= shape_color_d;
    end
  end

  assign busy        = busy_q;
  assign shape_color = shape_color_q;

endmodule

// File: tb/tb_t01_score_bcd_display.sv
// Directed bench for the score overlay; expectations queue up with a due cycle
// and a negedge monitor compares them against the DUT.
module tb_t01_score_bcd_display;

  localparam logic [2:0] C_BLACK  = 3'b000;
  localparam logic [2:0] C_WHITE  = 3'b111;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_GREEN  = 3'b010;
  localparam int K_COLOR = 0, K_BUSY = 1, K_DIGITS = 2, K_FLASH = 3;

  logic        clk, rst, frame_tick, busy;
  logic [13:0] score;
  logic [9:0]  x, y;
  logic [2:0]  shape_color;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    int          id;
  } exp_t;
  exp_t sbq[$];

  t01_score_bcd_display #(
    .SCORE_W(14), .DIGITS(4), .SCALE(2), .ORIGIN_X(245), .ORIGIN_Y(400),
    .VALUE_GAP(90), .BLANK_LZ(1), .FLASH_FRAMES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .x           (x),
    .y           (y),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .shape_color (shape_color)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_COLOR:  return "shape_color";
      K_BUSY:   return "busy";
      K_DIGITS: return "digits";
      K_FLASH:  return "flash";
      default:  return "unknown";
    endcase
  endfunction

  task automatic expect_at(input int due, input int kind, input logic [15:0] v, input int id);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = v;
    e.id   = id;
    sbq.push_back(e);
  endtask

  task automatic check_item(input exp_t e);
    logic [15:0] act;
    case (e.kind)
      K_COLOR:  act = 16'(shape_color);
      K_BUSY:   act = 16'(busy);
      K_DIGITS: act = 16'(dut.digits_q);
      K_FLASH:  act = 16'(dut.flash_q);
      default:  act = 16'hFFFF;
    endcase
    n_checks++;
    if (e.due != cyc) begin
      n_fail++;
      $display("FAIL %s #%0d: checked at cycle %0d, due %0d", kname(e.kind), e.id, cyc, e.due);
    end else if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s #%0d cycle %0d: got %0h expected %0h", kname(e.kind), e.id, cyc, act, e.exp);
    end
  endtask

  // Monitor: evaluate every expectation that has come due this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        check_item(sbq[i]);
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a pixel at the current cycle; its colour is due two cycles later.
  task automatic pixel(input int px, input int py, input logic [2:0] c, input int id);
    x = 10'(px);
    y = 10'(py);
    expect_at(cyc + 2, K_COLOR, 16'(c), id);
    tick();
  endtask

  int c;
  initial begin
    rst = 1'b0; score = '0; x = 10'd249; y = 10'd400; frame_tick = 1'b0;
    repeat (3) tick();
    expect_at(cyc, K_BUSY,   16'h0, 1);
    expect_at(cyc, K_COLOR,  16'h0, 2);
    expect_at(cyc, K_DIGITS, 16'h0, 3);
    expect_at(cyc, K_FLASH,  16'h0, 4);
    tick();
    rst = 1'b1;
    tick(); tick();
    expect_at(cyc + 1, K_COLOR, 16'(C_YELLOW), 5);

    // Reset in the middle of a conversion.
    score = 14'd1234; c = cyc;
    expect_at(c + 4, K_BUSY, 16'h1, 6);
    repeat (5) tick();
    rst = 1'b0;
    expect_at(cyc, K_BUSY,   16'h0, 7);
    expect_at(cyc, K_COLOR,  16'h0, 8);
    expect_at(cyc, K_DIGITS, 16'h0, 9);
    tick(); tick();
    rst = 1'b1; c = cyc;
    expect_at(c + 1,  K_BUSY,   16'h1, 10);
    expect_at(c + 15, K_DIGITS, 16'h0, 11);
    expect_at(c + 16, K_DIGITS, 16'h1234, 12);
    expect_at(c + 16, K_BUSY,   16'h0, 13);
    repeat (18) tick();

    // Score 0: only the least significant "0" is drawn.
    score = 14'd0; c = cyc;
    expect_at(c + 16, K_DIGITS, 16'h0000, 14);
    repeat (20) tick();
    pixel(387, 400, C_WHITE, 15);
    pixel(371, 400, C_BLACK, 16);

    // 0 -> 1234: busy window, commit, flash load, then one frame of flash.
    score = 14'd1234; c = cyc;
    for (int k = 1; k <= 15; k++) expect_at(c + k, K_BUSY, 16'h1, 20);
    expect_at(c + 16, K_BUSY,   16'h0, 21);
    expect_at(c + 16, K_DIGITS, 16'h1234, 22);
    expect_at(c + 16, K_FLASH,  16'd16, 23);
    repeat (17) tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    expect_at(cyc, K_FLASH, 16'd15, 24);
    pixel(341, 400, C_GREEN, 25);
    tick(); tick();

    // 42 with leading-zero blanking.
    score = 14'd42; c = cyc;
    expect_at(c + 16, K_DIGITS, 16'h0042, 30);
    repeat (17) tick();
    pixel(337, 400, C_BLACK, 31);
    pixel(371, 400, C_WHITE, 32);
    tick();

    // Overflow saturates to 9999 and does not retrigger conversion.
    score = 14'd12000; c = cyc;
    expect_at(c + 16, K_DIGITS, 16'h9999, 40);
    expect_at(c + 19, K_BUSY,   16'h0, 41);
    repeat (17) tick();
    pixel(339, 400, C_WHITE, 42);
    repeat (3) tick();

    // Score changes while busy: 5 commits first, then 7.
    score = 14'd5; c = cyc;
    expect_at(c + 16, K_DIGITS, 16'h0005, 50);
    expect_at(c + 16, K_BUSY,   16'h0, 51);
    expect_at(c + 18, K_BUSY,   16'h1, 52);
    expect_at(c + 25, K_DIGITS, 16'h0005, 53);
    expect_at(c + 33, K_DIGITS, 16'h0007, 54);
    expect_at(c + 33, K_BUSY,   16'h0, 55);
    repeat (3) tick();
    score = 14'd7;
    repeat (32) tick();

    // Label geometry and pipeline latency, one new pixel per cycle.
    pixel(249, 400, C_YELLOW, 60);
    pixel(245, 400, C_BLACK,  61);
    pixel(244, 400, C_BLACK,  62);
    pixel(295, 400, C_YELLOW, 63);
    pixel(249, 399, C_BLACK,  64);
    pixel(249, 424, C_BLACK,  65);
    pixel(249, 423, C_BLACK,  66);

    for (int k = 0; k < 60 && sbq.size() > 0; k++) tick();
    while (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s #%0d: never evaluated (due %0d)", kname(sbq[0].kind), sbq[0].id, sbq[0].due);
      sbq.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
